// File: rtl/serial_word_sequencer.sv
// Parallel/serial bridge for the bit-serial ALU: streams an operand pair LSB-first,
// rebuilds the serial result into a word and captures the final carry.
module serial_word_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start_valid,
  output logic             o_start_ready,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  input  logic [2:0]       i_func_in,
  output logic             o_alu_a,
  output logic             o_alu_b,
  output logic [2:0]       o_alu_func,
  output logic             o_alu_rst_n,
  input  logic             i_alu_out,
  input  logic             i_alu_c_out,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry
);

  // state   | meaning
  // S_IDLE  | ready for a request
  // S_CLEAR | ALU carry held in clear for one cycle
  // S_SHIFT | WIDTH cycles streaming operand bits, collecting result bits
  // S_CARRY | capture the carry left by the last bit
  // S_DONE  | result/carry presented until consumed
  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_CARRY,
    S_DONE
  } state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_clear;
  logic             w_shift;
  logic             w_capture;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_count;
  logic [2:0]       r_func;
  logic             r_carry;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_clear   = 1'b0;
    w_shift   = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start_valid) begin
          w_accept = 1'b1;
          w_next   = S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_clear = 1'b1;
        w_next  = S_SHIFT;
      end
      S_SHIFT: begin
        w_shift = 1'b1;
        if (r_count == LAST) w_next = S_CARRY;
      end
      S_CARRY: begin
        w_capture = 1'b1;
        w_next    = S_DONE;
      end
      S_DONE: begin
        if (i_res_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_result <= '0;
      r_count  <= '0;
      r_func   <= '0;
      r_carry  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a_sh <= i_op_a;
        r_b_sh <= i_op_b;
        r_func <= i_func_in;
      end
      if (w_clear) r_count <= '0;
      if (w_shift) begin
        r_result <= {i_alu_out, r_result[WIDTH-1:1]};
        r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
        r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
        // Saturate so the counter can never wrap past the last bit index.
        if (r_count != LAST) r_count <= r_count + 1'b1;
      end
      if (w_capture) r_carry <= i_alu_c_out;
    end
  end

  // Serial bits are gated by rst so the ALU sees zeros throughout reset.
  assign o_alu_a       = rst & w_shift & r_a_sh[0];
  assign o_alu_b       = rst & w_shift & r_b_sh[0];
  assign o_alu_func    = r_func;
  assign o_alu_rst_n   = rst & (r_state != S_CLEAR);
  assign o_start_ready = (r_state == S_IDLE);
  assign o_res_valid   = (r_state == S_DONE);
  assign o_result      = r_result;
  assign o_carry       = r_carry;

endmodule
